// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-ported register file: two combinational read ports, two write ports
// (port 1 has priority on an address collision), an optional hardwired-zero
// register 0, and a per-register pending-write scoreboard with a registered
// population count for RAW hazard detection at issue.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - reads forward same-cycle write data (and the resulting
//               pending state) combinationally, write port 1 winning.
//   undefined - reads see pre-edge storage and pending state only.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rAddr1,
    output logic [DATA_W-1:0] rData1,
    output logic              rBusy1,
    input  logic [ADDR_W-1:0] rAddr2,
    output logic [DATA_W-1:0] rData2,
    output logic              rBusy2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wAddr0,
    input  logic [DATA_W-1:0] wData0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wAddr1,
    input  logic [DATA_W-1:0] wData1,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsvAddr,
    output logic [ADDR_W:0]   busyCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [ADDR_W:0]   r_count;

    logic              w_we0;
    logic              w_we1;
    logic              w_rsv;
    logic [DEPTH-1:0]  w_pend_next;
    logic [ADDR_W:0]   w_count_next;

    // Effective enables: with a hardwired zero register, anything aimed at
    // address 0 is dropped before it can touch storage or the scoreboard.
    assign w_we0 = we0 && !((ZERO_REG != 0) && (wAddr0 == '0));
    assign w_we1 = we1 && !((ZERO_REG != 0) && (wAddr1 == '0));
    assign w_rsv = rsv && !((ZERO_REG != 0) && (rsvAddr == '0));

    // Next pending vector: writes retire producers, a reservation installs one.
    always_comb begin
        // NOTE: a default assignment first means every path drives the
        // variable, so no latch is inferred.
        w_pend_next = r_pend;
        if (w_we0) w_pend_next[wAddr0] = 1'b0;
        if (w_we1) w_pend_next[wAddr1] = 1'b0;
        // Applied last so a reservation beats a same-cycle retiring write.
        if (w_rsv) w_pend_next[rsvAddr] = 1'b1;
    end

    // Count is the popcount of the next pending vector, so it can never drift
    // out of step with the bits, underflow, or double count a re-reservation.
    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_next = w_count_next + (ADDR_W + 1)'(w_pend_next[i]);
        end
    end

    // Register storage: port 0 then port 1, so port 1 wins a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is reset on purpose -- reads must return 0 after
            // reset, so this storage cannot map to a reset-less RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments; with both writes to one address
            // the later statement (port 1) is the value that lands.
            if (w_we0) r_mem[wAddr0] <= wData0;
            if (w_we1) r_mem[wAddr1] <= wData1;
        end
    end

    // Scoreboard bits and their registered population count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend  <= '0;
            r_count <= '0;
        end else begin
            r_pend  <= w_pend_next;
            r_count <= w_count_next;
        end
    end

    assign busyCount = r_count;

    // Read port 1: storage/pending lookup, optional forwarding, zero override.
    always_comb begin
        rData1 = r_mem[rAddr1];
        rBusy1 = r_pend[rAddr1];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed while reset is held so reads stay at 0.
        if (rst && w_we1 && (wAddr1 == rAddr1)) begin
            rData1 = wData1;
            rBusy1 = w_rsv && (rsvAddr == rAddr1);
        end else if (rst && w_we0 && (wAddr0 == rAddr1)) begin
            rData1 = wData0;
            rBusy1 = w_rsv && (rsvAddr == rAddr1);
        end
`endif
        if ((ZERO_REG != 0) && (rAddr1 == '0)) begin
            rData1 = '0;
            rBusy1 = 1'b0;
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        rData2 = r_mem[rAddr2];
        rBusy2 = r_pend[rAddr2];
`ifdef REGFILE_BYPASS_EN
        if (rst && w_we1 && (wAddr1 == rAddr2)) begin
            rData2 = wData1;
            rBusy2 = w_rsv && (rsvAddr == rAddr2);
        end else if (rst && w_we0 && (wAddr0 == rAddr2)) begin
            rData2 = wData0;
            rBusy2 = w_rsv && (rsvAddr == rAddr2);
        end
`endif
        if ((ZERO_REG != 0) && (rAddr2 == '0)) begin
            rData2 = '0;
            rBusy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Drives two regfile_mp instances in lockstep: index 0 has ZERO_REG = 1,
// index 1 has ZERO_REG = 0. Expected values come from an array-based model of
// the register file semantics. Honours REGFILE_BYPASS_EN when defined.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rAddr1, rAddr2, wAddr0, wAddr1, rsvAddr;
    logic [31:0] wData0, wData1;
    logic        we0, we1, rsv;

    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic        rb1 [2];
    logic        rb2 [2];
    logic [5:0]  cnt [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_mem  [2][32];
    bit          m_pend [2][32];

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .rst(rst),
        .rAddr1(rAddr1), .rData1(rd1[0]), .rBusy1(rb1[0]),
        .rAddr2(rAddr2), .rData2(rd2[0]), .rBusy2(rb2[0]),
        .we0(we0), .wAddr0(wAddr0), .wData0(wData0),
        .we1(we1), .wAddr1(wAddr1), .wData1(wData1),
        .rsv(rsv), .rsvAddr(rsvAddr), .busyCount(cnt[0])
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst(rst),
        .rAddr1(rAddr1), .rData1(rd1[1]), .rBusy1(rb1[1]),
        .rAddr2(rAddr2), .rData2(rd2[1]), .rBusy2(rb2[1]),
        .we0(we0), .wAddr0(wAddr0), .wData0(wData0),
        .we1(we1), .wAddr1(wAddr1), .wData1(wData1),
        .rsv(rsv), .rsvAddr(rsvAddr), .busyCount(cnt[1])
    );

    // ---------------- reference model ----------------
    function automatic bit is_zero_inst(int k);
        return (k == 0);
    endfunction

    function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
        if (!rst) return 32'h0;
        if (is_zero_inst(k) && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wAddr1 == a) return wData1;
        if (we0 && wAddr0 == a) return wData0;
`endif
        return m_mem[k][a];
    endfunction

    function automatic logic exp_busy(int k, logic [4:0] a);
        if (!rst) return 1'b0;
        if (is_zero_inst(k) && a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if ((we1 && wAddr1 == a) || (we0 && wAddr0 == a)) return rsv && (rsvAddr == a);
`endif
        return m_pend[k][a];
    endfunction

    function automatic int exp_cnt(int k);
        int n = 0;
        foreach (m_pend[k][i]) n += m_pend[k][i];
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                m_mem[k][i]  = 32'h0;
                m_pend[k][i] = 1'b0;
            end
    endtask

    // Apply one clock edge's worth of architectural effect.
    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            bit zr = is_zero_inst(k);
            if (we0 && !(zr && wAddr0 == 5'd0)) begin
                m_mem[k][wAddr0]  = wData0;
                m_pend[k][wAddr0] = 1'b0;
            end
            if (we1 && !(zr && wAddr1 == 5'd0)) begin
                m_mem[k][wAddr1]  = wData1;
                m_pend[k][wAddr1] = 1'b0;
            end
            if (rsv && !(zr && rsvAddr == 5'd0)) m_pend[k][rsvAddr] = 1'b1;
        end
    endtask

    // Advance one edge; inputs are then driven 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_commit();
        #2;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; rsv = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // Power-on reset state
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (cnt[k] !== 6'd0 || rd1[k] !== 32'h0 || rb1[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got cnt=%0d rd=%h busy=%b, expected 0/0/0", k, cnt[k], rd1[k], rb1[k]);
            end
        end
        step();
        rst = 1'b1;
        // Write r5, reserve r7
        we0 = 1'b1; wAddr0 = 5'd5; wData0 = 32'hDEADBEEF;
        rsv = 1'b1; rsvAddr = 5'd7;
        step();
        // Next operation in flight, then reset lands between edges
        wAddr0 = 5'd6; wData0 = 32'h12345678; rsvAddr = 5'd8;
        rAddr1 = 5'd5; rAddr2 = 5'd7;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rd1[k] !== 32'hDEADBEEF || rb2[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL pre_reset[%0d]: got rd=%h busy=%b, expected deadbeef/1", k, rd1[k], rb2[k]);
            end
        end
        rst = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rd1[k] !== 32'h0 || rb2[k] !== 1'b0 || cnt[k] !== 6'd0) begin
                n_bad++;
                $display("FAIL midstream_reset[%0d]: got rd=%h busy=%b cnt=%0d, expected 0/0/0", k, rd1[k], rb2[k], cnt[k]);
            end
        end
        step();  // edge with reset held: write/reserve must be discarded
        rst = 1'b1;
        idle();
        rAddr2 = 5'd6;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rd2[k] !== 32'h0 || cnt[k] !== 6'd0) begin
                n_bad++;
                $display("FAIL reset_discard[%0d]: got rd=%h cnt=%0d, expected 0/0", k, rd2[k], cnt[k]);
            end
        end
    endtask

    task automatic test_collision();
        we0 = 1'b1; wAddr0 = 5'd9; wData0 = 32'h11111111;
        we1 = 1'b1; wAddr1 = 5'd9; wData1 = 32'h22222222;
        step();
        wAddr0 = 5'd3; wData0 = 32'hAAAA0003;
        wAddr1 = 5'd4; wData1 = 32'hBBBB0004;
        step();
        idle();
        rAddr1 = 5'd9; rAddr2 = 5'd3;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rd1[k] !== 32'h22222222) begin
                n_bad++;
                $display("FAIL collision_same[%0d]: got %h, expected 22222222", k, rd1[k]);
            end
            n_cmp++;
            if (rd2[k] !== 32'hAAAA0003) begin
                n_bad++;
                $display("FAIL collision_diff_p0[%0d]: got %h, expected aaaa0003", k, rd2[k]);
            end
        end
        rAddr2 = 5'd4;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rd2[k] !== 32'hBBBB0004) begin
                n_bad++;
                $display("FAIL collision_diff_p1[%0d]: got %h, expected bbbb0004", k, rd2[k]);
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] want_rd [2];
        logic        want_b  [2];
        int          want_c  [2];
        want_rd[0] = 32'h0;        want_b[0] = 1'b0; want_c[0] = 0;
        want_rd[1] = 32'hFFFFFFFF; want_b[1] = 1'b1; want_c[1] = 1;
        we0 = 1'b1; wAddr0 = 5'd0; wData0 = 32'hFFFFFFFF;
        rsv = 1'b1; rsvAddr = 5'd0;
        step();
        idle();
        rAddr1 = 5'd0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rd1[k] !== want_rd[k] || rb1[k] !== want_b[k] || cnt[k] !== 6'(want_c[k])) begin
                n_bad++;
                $display("FAIL zero_reg[%0d]: got rd=%h busy=%b cnt=%0d, expected %h/%b/%0d",
                         k, rd1[k], rb1[k], cnt[k], want_rd[k], want_b[k], want_c[k]);
            end
        end
        // Retire r0 in the ordinary-storage instance
        we0 = 1'b1; wData0 = 32'h0;
        step();
        idle();
    endtask

    task automatic test_scoreboard();
        for (int i = 0; i < 3; i++) begin
            rsv = 1'b1; rsvAddr = 5'(3 + i);
            step();
            idle();
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (cnt[k] !== 6'(i + 1)) begin
                    n_bad++;
                    $display("FAIL sb_reserve[%0d]: got %0d, expected %0d", k, cnt[k], i + 1);
                end
            end
        end
        we0 = 1'b1; wAddr0 = 5'd3; wData0 = 32'h33;
        we1 = 1'b1; wAddr1 = 5'd4; wData1 = 32'h44;
        step();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (cnt[k] !== 6'd1) begin
                n_bad++;
                $display("FAIL sb_dual_clear[%0d]: got %0d, expected 1", k, cnt[k]);
            end
        end
        we0 = 1'b1; wAddr0 = 5'd5; wData0 = 32'h55;
        rsv = 1'b1; rsvAddr = 5'd5;
        step();
        idle();
        rAddr1 = 5'd5;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rb1[k] !== 1'b1 || cnt[k] !== 6'd1 || rd1[k] !== 32'h55) begin
                n_bad++;
                $display("FAIL sb_set_wins[%0d]: got busy=%b cnt=%0d rd=%h, expected 1/1/00000055", k, rb1[k], cnt[k], rd1[k]);
            end
        end
        we1 = 1'b1; wAddr1 = 5'd5; wData1 = 32'h56;
        step();
        idle();
    endtask

    task automatic test_fill_drain();
        int prev;
        for (int i = 1; i < 32; i++) begin
            rsv = 1'b1; rsvAddr = 5'(i);
            step();
        end
        rsvAddr = 5'd10;  // re-reserve: must not double count
        step();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (cnt[k] !== 6'd31) begin
                n_bad++;
                $display("FAIL fill_count[%0d]: got %0d, expected 31", k, cnt[k]);
            end
        end
        prev = 31;
        for (int i = 1; i < 32; i += 2) begin
            we0 = 1'b1; wAddr0 = 5'(i); wData0 = $urandom;
            we1 = (i < 31); wAddr1 = 5'(i + 1); wData1 = $urandom;
            step();
            idle();
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (cnt[k] !== 6'(exp_cnt(k)) || int'(cnt[k]) > prev) begin
                    n_bad++;
                    $display("FAIL drain_count[%0d]: got %0d, expected %0d", k, cnt[k], exp_cnt(k));
                end
            end
            prev = int'(cnt[0]);
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (cnt[k] !== 6'd0) begin
                n_bad++;
                $display("FAIL drain_final[%0d]: got %0d, expected 0", k, cnt[k]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] old [2];
        for (int k = 0; k < 2; k++) old[k] = m_mem[k][12];
        we0 = 1'b1; wAddr0 = 5'd12; wData0 = 32'h0000ABCD;
        rAddr1 = 5'd12;
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
            want = 32'h0000ABCD;
`else
            want = old[k];
`endif
            n_cmp++;
            if (rd1[k] !== want) begin
                n_bad++;
                $display("FAIL bypass_same_cycle[%0d]: got %h, expected %h", k, rd1[k], want);
            end
        end
        step();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rd1[k] !== 32'h0000ABCD) begin
                n_bad++;
                $display("FAIL bypass_next_cycle[%0d]: got %h, expected 0000abcd", k, rd1[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            // Narrow address range on writes/reserves to force collisions
            we0 = ($urandom_range(0, 2) != 0); wAddr0 = 5'($urandom_range(0, 7)); wData0 = $urandom;
            we1 = ($urandom_range(0, 2) != 0); wAddr1 = 5'($urandom_range(0, 7)); wData1 = $urandom;
            rsv = ($urandom_range(0, 1) != 0); rsvAddr = 5'($urandom_range(0, 9));
            rAddr1 = 5'($urandom_range(0, 9)); rAddr2 = 5'($urandom_range(0, 31));
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (rd1[k] !== exp_rd(k, rAddr1) || rb1[k] !== exp_busy(k, rAddr1)) begin
                    n_bad++;
                    $display("FAIL rand_port1[%0d] it%0d a=%0d: got %h/%b, expected %h/%b",
                             k, n, rAddr1, rd1[k], rb1[k], exp_rd(k, rAddr1), exp_busy(k, rAddr1));
                end
                n_cmp++;
                if (rd2[k] !== exp_rd(k, rAddr2) || rb2[k] !== exp_busy(k, rAddr2)) begin
                    n_bad++;
                    $display("FAIL rand_port2[%0d] it%0d a=%0d: got %h/%b, expected %h/%b",
                             k, n, rAddr2, rd2[k], rb2[k], exp_rd(k, rAddr2), exp_busy(k, rAddr2));
                end
                n_cmp++;
                if (cnt[k] !== 6'(exp_cnt(k))) begin
                    n_bad++;
                    $display("FAIL rand_count[%0d] it%0d: got %0d, expected %0d", k, n, cnt[k], exp_cnt(k));
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        rAddr1 = 5'd5; rAddr2 = 5'd7;
        wAddr0 = '0; wAddr1 = '0; rsvAddr = '0;
        wData0 = '0; wData1 = '0;
        model_reset();
        #2;
        test_reset();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_fill_drain();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write MIPS register file.
- Two combinational read ports and two write ports, with deterministic write-collision priority.
- Optional hardwired-zero register.
- Per-register pending-write scoreboard, so the issue stage can detect RAW hazards against in-flight producers.
- Sits between decode/issue and writeback in the pipelined core.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/reservations; 0 = register 0 is ordinary storage

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous, active-low reset
rAddr1  input  ADDR_W  read port 1 address
rData1  output  DATA_W  read port 1 data
rBusy1  output  1  pending bit of rAddr1
rAddr2  input  ADDR_W  read port 2 address
rData2  output  DATA_W  read port 2 data
rBusy2  output  1  pending bit of rAddr2
we0  input  1  write port 0 enable
wAddr0  input  ADDR_W  write port 0 address
wData0  input  DATA_W  write port 0 data
we1  input  1  write port 1 enable (higher priority)
wAddr1  input  ADDR_W  write port 1 address
wData1  input  DATA_W  write port 1 data
rsv  input  1  reserve: mark rsvAddr as pending a future write
rsvAddr  input  ADDR_W  register to reserve
busyCount  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (rst low, asynchronous):
  - all storage cleared to 0, all pending bits cleared, busyCount = 0.
  - rData1/rData2 then read 0; rBusy1/rBusy2 read 0.
  - Takes effect immediately, including mid-operation; any write, reservation or count update in the same cycle is discarded.
- Reads:
  - Combinational, zero latency.
  - rDataN = storage[rAddrN]; rBusyN = pending[rAddrN].
- Writes:
  - Committed on the rising clk edge when weN = 1.
  - New value is visible on reads in the cycle after the edge.
- Write collision:
  - we0 = we1 = 1 with wAddr0 == wAddr1: wData1 is stored, wData0 is dropped.
  - Different addresses: both are stored.
- Zero register (ZERO_REG = 1):
  - Address 0 always reads 0 with busy = 0.
  - Writes and reservations to address 0 are ignored and never counted.
- Scoreboard (per-register pending bit, updated on the clk edge):
  - Clear: any write (we0 or we1) to address A clears pending[A].
  - Set: rsv = 1 sets pending[rsvAddr].
  - Simultaneous write and reserve to the same A: set wins, pending[A] = 1 (new producer supersedes the retiring one).
  - Reserving an already-pending register leaves it at 1, with no double count.
  - Writing a non-pending register writes data; pending is unchanged at 0 and the count is unchanged.
- busyCount:
  - Registered; always equals the population count of pending bits after the edge.
  - Net change per cycle is in {-2, -1, 0, +1}.
  - Must never underflow or exceed 2**ADDR_W, or 2**ADDR_W - 1 when ZERO_REG = 1.
- Reset deassertion is synchronous to clk at integration level; no requirement here beyond the asynchronous assert.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read address matches an enabled write address this cycle (non-zero when ZERO_REG = 1): rDataN returns the incoming write data combinationally, port 1 winning on collision.
  - rBusyN returns 0 for that address unless rsv targets the same address this cycle, in which case it returns 1.
- Undefined:
  - Reads return pre-edge storage and pending state only.
  - Write-to-read latency is 1 cycle.

Test Plan:
1. Reset mid-stream: write 0xDEADBEEF to r5, reserve r7, assert rst low between edges -> rData(r5) = 0, rBusy(r7) = 0, busyCount = 0 immediately.
2. Collision: we0 = we1 = 1, wAddr0 = wAddr1 = 9, wData0 = 0x11111111, wData1 = 0x22222222 -> next cycle rData1(r9) = 0x22222222; separate addresses 3/4 -> both stored.
3. Zero reg (ZERO_REG = 1): write 0xFFFFFFFF to r0, rsv r0 -> rData = 0, rBusy = 0, busyCount = 0. Repeat with ZERO_REG = 0 -> reads 0xFFFFFFFF, count 1.
4. Scoreboard: rsv r3, r4, r5 on consecutive cycles -> busyCount 1, 2, 3. Then write r3 and r4 on both ports in one cycle -> count 1. Then rsv r5 while writing r5 -> r5 busy, count 1.
5. Fill and drain: reserve all 31 non-zero registers -> busyCount = 31; re-reserve r10 -> still 31; write all back -> 0, never negative.
6. Bypass: write 0x0000ABCD to r12 with rAddr1 = 12 in the same cycle -> defined: rData1 = 0x0000ABCD that cycle; undefined: old value that cycle, 0x0000ABCD next.
